// File: rtl/dac_frontend.sv
// dac_frontend: per-rail gain and DC-offset correction with saturation, DAC
// code formatting (two's-complement / offset-binary) and an elastic FIFO with
// fill/run control between the interpolator (cannot stall) and the DAC
// (may back-pressure). Sticky overflow/underrun reporting.
// Optional build macro DAC_FRONTEND_SAT_COUNT_EN adds the sat_count port.

module dac_frontend #(
    parameter int DATA_WIDTH  = 16,
    parameter int GAIN_WIDTH  = 16,
    parameter int FIFO_DEPTH  = 8,
    parameter int START_LEVEL = 4
) (
    input  logic                        clk_400,
    input  logic                        rst,
    input  logic                        en,
    input  logic [DATA_WIDTH-1:0]       in_i,
    input  logic [DATA_WIDTH-1:0]       in_q,
    input  logic                        in_valid,
    input  logic [GAIN_WIDTH-1:0]       gain_i,
    input  logic [GAIN_WIDTH-1:0]       gain_q,
    input  logic [DATA_WIDTH-1:0]       offset_i,
    input  logic [DATA_WIDTH-1:0]       offset_q,
    input  logic                        offset_binary,
    output logic [DATA_WIDTH-1:0]       dac_i,
    output logic [DATA_WIDTH-1:0]       dac_q,
    output logic                        dac_valid,
    input  logic                        dac_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overflow,
    output logic                        underrun,
    input  logic                        clr_flags
`ifdef DAC_FRONTEND_SAT_COUNT_EN
    ,
    output logic [15:0]                 sat_count
`endif
);

    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int LW    = PW + 1;
    localparam int PRODW = DATA_WIDTH + GAIN_WIDTH;
    localparam int FRAC  = GAIN_WIDTH - 2;
    localparam int WORDW = 2 * DATA_WIDTH;

    localparam logic signed [PRODW-1:0] RND_V =
        {{(PRODW-1){1'b0}}, 1'b1} << (FRAC - 1);
    localparam logic signed [PRODW-1:0] MAX_V =
        {{(PRODW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [PRODW-1:0] MIN_V =
        {{(PRODW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    // Round half up to the output LSB, then add the sign-extended offset.
    function automatic logic signed [PRODW-1:0] scale_acc(
        input logic signed [PRODW-1:0] prod,
        input logic [DATA_WIDTH-1:0]   offset
    );
        logic signed [PRODW-1:0] off_ext;
        off_ext = {{(PRODW-DATA_WIDTH){offset[DATA_WIDTH-1]}}, offset};
        return ((prod + RND_V) >>> FRAC) + off_ext;
    endfunction

    // Clamp the wide accumulator into the signed output range.
    function automatic logic [DATA_WIDTH-1:0] clamp_word(
        input logic signed [PRODW-1:0] acc
    );
        logic [DATA_WIDTH-1:0] res;
        if (acc > MAX_V) begin
            res = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else if (acc < MIN_V) begin
            res = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            res = acc[DATA_WIDTH-1:0];
        end
        return res;
    endfunction

    // Pipeline registers
    logic                          v1_q, v2_q, v3_q;
    logic                          v1_d, v2_d, v3_d;
    logic signed [PRODW-1:0]       prod_i_q, prod_q_q, prod_i_d, prod_q_d;
    logic signed [PRODW-1:0]       acc_i_s, acc_q_s;
    logic signed [PRODW-1:0]       xi_ext_s, xq_ext_s, gi_ext_s, gq_ext_s;
    logic [DATA_WIDTH-1:0]         y_i_q, y_q_q, y_i_d, y_q_d;
    logic [DATA_WIDTH-1:0]         w_i_q, w_q_q, w_i_d, w_q_d;

    // FIFO and output state
    logic [WORDW-1:0]              mem_q [FIFO_DEPTH];
    logic [PW-1:0]                 wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
    logic [LW-1:0]                 level_q, level_d, remain_s;
    logic                          push_s, pop_s, full_s, wr_en_s, ovf_set_s;
    logic [DATA_WIDTH-1:0]         idle_word_s;
    logic [WORDW-1:0]              head_d;
    logic [DATA_WIDTH-1:0]         dac_i_q, dac_q_q;
    logic                          dac_valid_q, dac_valid_d;
    logic                          ovf_q, ovf_d, und_q, und_d, und_set_s;
    state_e                        state_q, state_d;

    // Datapath: S1 multiply, S2 round/offset/saturate, S3 code formatting.
    // Valids are gated by en so disabling the block discards in-flight samples.
    always_comb begin
        xi_ext_s = {{GAIN_WIDTH{in_i[DATA_WIDTH-1]}}, in_i};
        xq_ext_s = {{GAIN_WIDTH{in_q[DATA_WIDTH-1]}}, in_q};
        gi_ext_s = {{DATA_WIDTH{gain_i[GAIN_WIDTH-1]}}, gain_i};
        gq_ext_s = {{DATA_WIDTH{gain_q[GAIN_WIDTH-1]}}, gain_q};
        prod_i_d = xi_ext_s * gi_ext_s;
        prod_q_d = xq_ext_s * gq_ext_s;
        acc_i_s  = scale_acc(prod_i_q, offset_i);
        acc_q_s  = scale_acc(prod_q_q, offset_q);
        y_i_d    = clamp_word(acc_i_s);
        y_q_d    = clamp_word(acc_q_s);
        w_i_d    = {y_i_q[DATA_WIDTH-1] ^ offset_binary, y_i_q[DATA_WIDTH-2:0]};
        w_q_d    = {y_q_q[DATA_WIDTH-1] ^ offset_binary, y_q_q[DATA_WIDTH-2:0]};
        v1_d     = in_valid & en;
        v2_d     = v1_q & en;
        v3_d     = v2_q & en;
    end

    // Pipeline stage registers; only the valids need clearing on reset.
    always_ff @(posedge clk_400) begin
        if (rst) begin
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            v3_q     <= 1'b0;
            prod_i_q <= '0;
            prod_q_q <= '0;
            y_i_q    <= '0;
            y_q_q    <= '0;
            w_i_q    <= '0;
            w_q_q    <= '0;
        end else begin
            v1_q     <= v1_d;
            v2_q     <= v2_d;
            v3_q     <= v3_d;
            prod_i_q <= prod_i_d;
            prod_q_q <= prod_q_d;
            y_i_q    <= y_i_d;
            y_q_q    <= y_q_d;
            w_i_q    <= w_i_d;
            w_q_q    <= w_q_d;
        end
    end

    // FIFO control: push from S3, pop on DAC handshake, flush while disabled,
    // and precompute the next head so the DAC outputs come straight from flops.
    always_comb begin
        push_s      = v3_q & en;
        pop_s       = dac_valid_q & dac_ready & (level_q != '0);
        full_s      = (level_q == LW'(FIFO_DEPTH));
        wr_en_s     = push_s & (~full_s | pop_s);
        ovf_set_s   = push_s & full_s & ~pop_s;
        idle_word_s = {offset_binary, {(DATA_WIDTH-1){1'b0}}};
        if (!en) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_d = wr_ptr_q + PW'(1'b1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1'b1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            if (wr_en_s && !pop_s) begin
                level_d = level_q + LW'(1'b1);
            end else if (pop_s && !wr_en_s) begin
                level_d = level_q - LW'(1'b1);
            end else begin
                level_d = level_q;
            end
        end
        if (pop_s) begin
            remain_s = level_q - LW'(1'b1);
        end else begin
            remain_s = level_q;
        end
        // An otherwise-empty FIFO receiving a push forwards the pushed word.
        if (level_d == '0) begin
            head_d = {idle_word_s, idle_word_s};
        end else if (remain_s == '0) begin
            head_d = {w_i_q, w_q_q};
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
        ovf_d = ovf_set_s | (ovf_q & ~clr_flags);
        und_d = und_set_s | (und_q & ~clr_flags);
    end

    // FIFO storage; contents are qualified by the pointers, so no reset.
    always_ff @(posedge clk_400) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= {w_i_q, w_q_q};
        end
    end

    // FIFO pointers, occupancy, registered DAC outputs and sticky flags.
    always_ff @(posedge clk_400) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            dac_i_q     <= '0;
            dac_q_q     <= '0;
            dac_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            und_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            dac_i_q     <= head_d[WORDW-1:DATA_WIDTH];
            dac_q_q     <= head_d[DATA_WIDTH-1:0];
            dac_valid_q <= dac_valid_d;
            ovf_q       <= ovf_d;
            und_q       <= und_d;
        end
    end

    // Fill/run state register.
    always_ff @(posedge clk_400) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Fill/run next state; an empty FIFO asked for data in RUN is an underrun.
    always_comb begin
        state_d   = state_q;
        und_set_s = 1'b0;
        if (!en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_FILL;
                end
                ST_FILL: begin
                    if (level_q >= LW'(START_LEVEL)) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
                ST_RUN: begin
                    if ((level_q == '0) && dac_ready) begin
                        und_set_s = 1'b1;
                        state_d   = ST_FILL;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        dac_valid_d = (state_d == ST_RUN);
    end

    assign dac_i      = dac_i_q;
    assign dac_q      = dac_q_q;
    assign dac_valid  = dac_valid_q;
    assign fifo_level = level_q;
    assign overflow   = ovf_q;
    assign underrun   = und_q;

`ifdef DAC_FRONTEND_SAT_COUNT_EN
    logic        sat_i_s, sat_q_s;
    logic [1:0]  sat_inc_s;
    logic [16:0] sat_sum_s;
    logic [15:0] sat_cnt_q, sat_cnt_d;

    // Count clamped rails in S2; a clear collapses the base but keeps this cycle's hits.
    always_comb begin
        sat_i_s   = v1_q & en & ((acc_i_s > MAX_V) | (acc_i_s < MIN_V));
        sat_q_s   = v1_q & en & ((acc_q_s > MAX_V) | (acc_q_s < MIN_V));
        sat_inc_s = {1'b0, sat_i_s} + {1'b0, sat_q_s};
        if (clr_flags) begin
            sat_sum_s = {15'd0, sat_inc_s};
        end else begin
            sat_sum_s = {1'b0, sat_cnt_q} + {15'd0, sat_inc_s};
        end
        if (sat_sum_s[16]) begin
            sat_cnt_d = 16'hFFFF;
        end else begin
            sat_cnt_d = sat_sum_s[15:0];
        end
    end

    // Saturation event counter register.
    always_ff @(posedge clk_400) begin
        if (rst) begin
            sat_cnt_q <= 16'd0;
        end else begin
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign sat_count = sat_cnt_q;
`endif

endmodule

// File: tb/tb_dac_frontend.sv
// Scoreboard bench for dac_frontend: a transaction-level model (sample queue,
// occupancy count, 3-cycle delay line) predicts which corrected words reach
// the FIFO; a negedge monitor compares every presented DAC word and status.

module tb_dac_frontend;

    localparam int DEPTH = 8;
    localparam int START = 4;

    logic        clk_400;
    logic        rst, en, in_valid, offset_binary, dac_ready, clr_flags;
    logic [15:0] in_i, in_q, gain_i, gain_q, offset_i, offset_q;
    logic [15:0] dac_i, dac_q;
    logic        dac_valid, overflow, underrun;
    logic [3:0]  fifo_level;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Reference model state (0 = IDLE, 1 = FILL, 2 = RUN)
    int          m_state = 0;
    int          m_cnt   = 0;
    bit          m_ovf   = 1'b0;
    bit          m_und   = 1'b0;
    bit          m_ob    = 1'b0;
    logic [31:0] sb[$];
    bit          dv[3];
    logic [31:0] dw[3];

    dac_frontend #(.DATA_WIDTH(16), .GAIN_WIDTH(16), .FIFO_DEPTH(DEPTH), .START_LEVEL(START)) dut (
        .clk_400(clk_400), .rst(rst), .en(en), .in_i(in_i), .in_q(in_q), .in_valid(in_valid),
        .gain_i(gain_i), .gain_q(gain_q), .offset_i(offset_i), .offset_q(offset_q),
        .offset_binary(offset_binary), .dac_i(dac_i), .dac_q(dac_q), .dac_valid(dac_valid),
        .dac_ready(dac_ready), .fifo_level(fifo_level), .overflow(overflow),
        .underrun(underrun), .clr_flags(clr_flags)
    );

    initial clk_400 = 1'b0;
    always #5 clk_400 = ~clk_400;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Corrected word from plain integer arithmetic: x*g/2^14 rounded half up, + offset, clamp.
    function automatic logic [15:0] ref_rail(input logic [15:0] x, input logic [15:0] g,
                                             input logic [15:0] off, input bit ob);
        longint p;
        longint y;
        logic [15:0] w;
        p = longint'($signed(x)) * longint'($signed(g));
        y = (p + 64'sd8192) >>> 14;
        y = y + longint'($signed(off));
        if (y > 64'sd32767) y = 64'sd32767;
        else if (y < -64'sd32768) y = -64'sd32768;
        w = y[15:0];
        w[15] = w[15] ^ ob;
        return w;
    endfunction

    task automatic model_step();
        bit push, pop, ovf_set, und_set;
        int cnt_old;
        if (rst) begin
            m_state = 0; m_cnt = 0; m_ovf = 1'b0; m_und = 1'b0;
            sb.delete();
            for (int k = 0; k < 3; k++) dv[k] = 1'b0;
        end else begin
            cnt_old = m_cnt;
            push    = dv[2] && en;
            pop     = (m_state == 2) && dac_ready && (m_cnt > 0);
            und_set = en && (m_state == 2) && (m_cnt == 0) && dac_ready;
            ovf_set = 1'b0;
            if (!en) begin
                m_cnt = 0;
                sb.delete();
            end else if (push) begin
                if (m_cnt == DEPTH && !pop) begin
                    ovf_set = 1'b1;
                end else begin
                    sb.push_back(dw[2]);
                    if (!pop) m_cnt++;
                end
            end else if (pop) begin
                m_cnt--;
            end
            m_ovf = ovf_set || (m_ovf && !clr_flags);
            m_und = und_set || (m_und && !clr_flags);
            if (!en) m_state = 0;
            else if (m_state == 0) m_state = 1;
            else if (m_state == 1 && cnt_old >= START) m_state = 2;
            else if (m_state == 2 && und_set) m_state = 1;
            dv[2] = dv[1] && en; dw[2] = dw[1];
            dv[1] = dv[0] && en; dw[1] = dw[0];
            dv[0] = in_valid && en;
            dw[0] = {ref_rail(in_i, gain_i, offset_i, offset_binary),
                     ref_rail(in_q, gain_q, offset_q, offset_binary)};
        end
        m_ob = offset_binary;
    endtask

    task automatic monitor_step();
        logic [31:0] idle;
        if (!chk_en) return;
        check("fifo_level", {28'd0, fifo_level}, m_cnt);
        check("dac_valid", {31'd0, dac_valid}, {31'd0, (m_state == 2)});
        check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        check("underrun", {31'd0, underrun}, {31'd0, m_und});
        if (dac_valid && fifo_level != 4'd0) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL head_word: got 0x%0h, expected no word (queue empty) at %0t", {dac_i, dac_q}, $time);
            end else begin
                check("head_word", {dac_i, dac_q}, sb[0]);
                if (dac_ready) void'(sb.pop_front());
            end
        end else if (dac_valid) begin
            idle = {m_ob, 15'd0, m_ob, 15'd0};
            check("idle_code", {dac_i, dac_q}, idle);
        end
    endtask

    initial forever begin
        @(posedge clk_400);
        model_step();
    end

    initial forever begin
        @(negedge clk_400);
        monitor_step();
    end

    task automatic tick();
        @(posedge clk_400);
        #1;
    endtask

    task automatic feed(input logic [15:0] xi, input logic [15:0] xq);
        in_valid = 1'b1; in_i = xi; in_q = xq;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic set_cfg(input logic [15:0] gi, input logic [15:0] gq,
                           input logic [15:0] oi, input logic [15:0] oq, input logic ob);
        gain_i = gi; gain_q = gq; offset_i = oi; offset_q = oq; offset_binary = ob;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; in_valid = 1'b0; in_i = 16'd0; in_q = 16'd0;
        dac_ready = 1'b0; clr_flags = 1'b0;
        set_cfg(16'h4000, 16'h4000, 16'h0000, 16'h0000, 1'b0);
        repeat (2) @(posedge clk_400);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;
        check("rst_dac_i", {16'd0, dac_i}, 32'h0);
        check("rst_dac_q", {16'd0, dac_q}, 32'h0);
        check("rst_valid", {31'd0, dac_valid}, 32'h0);
        check("rst_level", {28'd0, fifo_level}, 32'h0);
        check("rst_flags", {30'd0, overflow, underrun}, 32'h0);

        // Unity pass-through, then drain into an underrun.
        en = 1'b1; dac_ready = 1'b1;
        feed(16'h1234, 16'h0001);
        feed(16'h8000, 16'h7FFF);
        feed(16'h7FFF, 16'h8000);
        for (int k = 0; k < 20; k++) feed(16'($urandom), 16'($urandom));
        idle_cycles(12);
        check("underrun_after_drain", {31'd0, underrun}, 32'h1);

        // Gain, offset and saturation.
        set_cfg(16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000, 1'b0);
        feed(16'h6000, 16'hA000);
        feed(16'hA000, 16'h6000);
        feed(16'h0100, 16'hFF00);
        feed(16'h0000, 16'h0001);
        idle_cycles(4);
        set_cfg(16'h2000, 16'hC000, 16'h0010, 16'hFFF0, 1'b0);
        feed(16'h1000, 16'h1000);
        for (int k = 0; k < 3; k++) feed(16'($urandom), 16'($urandom));
        idle_cycles(12);

        // Offset-binary coding, including the idle code on underrun.
        set_cfg(16'h4000, 16'h4000, 16'h0000, 16'h0000, 1'b1);
        feed(16'h0000, 16'h7FFF);
        feed(16'h7FFF, 16'h0000);
        feed(16'h8000, 16'h1234);
        feed(16'hFFFF, 16'h8001);
        idle_cycles(12);

        // Overflow: DAC stalled while the source keeps streaming.
        set_cfg(16'h4000, 16'h4000, 16'h0000, 16'h0000, 1'b0);
        idle_cycles(4);
        dac_ready = 1'b0;
        for (int k = 0; k < 14; k++) feed(16'($urandom), 16'($urandom));
        idle_cycles(4);
        check("ovf_level_full", {28'd0, fifo_level}, 32'd8);
        check("ovf_flag_set", {31'd0, overflow}, 32'h1);
        dac_ready = 1'b1;
        idle_cycles(12);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        check("ovf_cleared", {31'd0, overflow}, 32'h0);

        // Mid-stream reset with five buffered samples.
        dac_ready = 1'b0;
        for (int k = 0; k < 5; k++) feed(16'($urandom), 16'($urandom));
        idle_cycles(4);
        check("pre_rst_level", {28'd0, fifo_level}, 32'd5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("post_rst_valid", {31'd0, dac_valid}, 32'h0);
        check("post_rst_level", {28'd0, fifo_level}, 32'h0);
        check("post_rst_flags", {30'd0, overflow, underrun}, 32'h0);
        dac_ready = 1'b1;
        for (int k = 0; k < 8; k++) feed(16'($urandom), 16'($urandom));
        idle_cycles(12);

        // Disable with five buffered samples: flushed, flags kept.
        dac_ready = 1'b0;
        for (int k = 0; k < 5; k++) feed(16'($urandom), 16'($urandom));
        idle_cycles(4);
        en = 1'b0;
        tick();
        check("dis_valid", {31'd0, dac_valid}, 32'h0);
        check("dis_level", {28'd0, fifo_level}, 32'h0);
        check("dis_und_kept", {31'd0, underrun}, 32'h1);
        tick();
        en = 1'b1; dac_ready = 1'b1;
        for (int k = 0; k < 8; k++) feed(16'($urandom), 16'($urandom));
        idle_cycles(12);

        // Randomized segments with fresh gains/offsets/coding each segment.
        for (int seg = 0; seg < 4; seg++) begin
            idle_cycles(6);
            set_cfg(16'($urandom), 16'($urandom),
                    16'($urandom_range(0, 511)) - 16'd256,
                    16'($urandom_range(0, 511)) - 16'd256,
                    1'($urandom_range(0, 1)));
            for (int c = 0; c < 700; c++) begin
                in_valid  = ($urandom_range(0, 9) < 7);
                in_i      = 16'($urandom);
                in_q      = 16'($urandom);
                dac_ready = ($urandom_range(0, 9) < 6);
                clr_flags = ($urandom_range(0, 49) == 0);
                en        = ($urandom_range(0, 199) != 0);
                tick();
            end
            in_valid = 1'b0; clr_flags = 1'b0; en = 1'b1; dac_ready = 1'b1;
        end
        idle_cycles(12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
